// File: rtl/uc_pkg.sv
// rtl/uc_pkg.sv - shared types and field positions for the unidade_controle slice
// Purpose: FSM state enum, instruction field bit positions, opcode flag bits, HALT opcode.
// Ports: none (package).
package uc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_READ,
    ST_EXEC,
    ST_WRITE,
    ST_HALT
  } state_t;

  localparam int INSTR_W = 32;

  // Instruction word layout; rb and imm overlap on purpose.
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RC_MSB  = 25;
  localparam int RC_LSB  = 21;
  localparam int RA_MSB  = 20;
  localparam int RA_LSB  = 16;
  localparam int RB_MSB  = 15;
  localparam int RB_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  // Opcode flag bits; op[3:0] is the ALU operation.
  localparam int OP_IMM_BIT = 5;
  localparam int OP_WB_BIT  = 4;

  localparam logic [5:0] OP_HALT = 6'h3F;

endpackage

// File: rtl/uc_instr_decoder.sv
// rtl/uc_instr_decoder.sv - combinational field extraction from the captured instruction
// Purpose: split the instruction register into addresses, immediate and opcode flags.
// Ports: ir (captured instruction) in; rc/ra/rb addresses, imm, imm_flag, wb_en,
//        is_halt, alu_op out.
module uc_instr_decoder
  import uc_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [4:0]         rc,
  output logic [4:0]         ra,
  output logic [4:0]         rb,
  output logic [15:0]        imm,
  output logic               imm_flag,
  output logic               wb_en,
  output logic               is_halt,
  output logic [3:0]         alu_op
);

  logic [5:0] op;

  assign op       = ir[OP_MSB:OP_LSB];
  assign rc       = ir[RC_MSB:RC_LSB];
  assign ra       = ir[RA_MSB:RA_LSB];
  assign rb       = ir[RB_MSB:RB_LSB];
  assign imm      = ir[IMM_MSB:IMM_LSB];
  assign imm_flag = op[OP_IMM_BIT];
  assign wb_en    = op[OP_WB_BIT];
  assign alu_op   = op[3:0];
  assign is_halt  = (op == OP_HALT);

endmodule

// File: rtl/unidade_controle.sv
// rtl/unidade_controle.sv - multi-cycle decode/control stage in front of the register bank
// Purpose: accept one instruction per handshake and sequence IDLE->DECODE->READ->EXEC->
//          (WRITE)->IDLE, driving the bank RW control and ALU launch; counts retirements.
// Option: UC_R0_ZERO_EN - writeback to register 0 is skipped (no WRITE cycle).
// Ports: clk, rst (sync, active-high); instr_valid/instr/instr_ready handshake;
//        alu_result/alu_done in, alu_start/alu_op out; regA/regB/regC, RW, imediato,
//        flagImediato, dado to the bank; halted, instr_count status.
module unidade_controle
  import uc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_done,
  output logic              alu_start,
  output logic [3:0]        alu_op,
  output logic [ADDR_W-1:0] regA,
  output logic [ADDR_W-1:0] regB,
  output logic [ADDR_W-1:0] regC,
  output logic              RW,
  output logic [DATA_W-1:0] imediato,
  output logic              flagImediato,
  output logic [DATA_W-1:0] dado,
  output logic              halted,
  output logic [15:0]       instr_count
);

  state_t              state, state_nx;
  logic [INSTR_W-1:0]  ir;
  logic                exec_first;
  logic                retire;
  logic                do_write;

  logic [4:0]  dec_rc, dec_ra, dec_rb;
  logic [15:0] dec_imm;
  logic        dec_imm_flag, dec_wb_en, dec_is_halt;
  logic [3:0]  dec_alu_op;

  // Fields come straight off the instruction register, so they are valid from the
  // DECODE cycle and hold until the next instruction is accepted.
  uc_instr_decoder u_dec (
    .ir       (ir),
    .rc       (dec_rc),
    .ra       (dec_ra),
    .rb       (dec_rb),
    .imm      (dec_imm),
    .imm_flag (dec_imm_flag),
    .wb_en    (dec_wb_en),
    .is_halt  (dec_is_halt),
    .alu_op   (dec_alu_op)
  );

`ifdef UC_R0_ZERO_EN
  assign do_write = dec_wb_en && (dec_rc != 5'd0);
`else
  assign do_write = dec_wb_en;
`endif

  always_comb begin
    state_nx = state;
    retire   = 1'b0;
    case (state)
      ST_IDLE:   if (instr_valid) state_nx = ST_DECODE;
      ST_DECODE: begin
        if (dec_is_halt) begin
          state_nx = ST_HALT;
          retire   = 1'b1;
        end else begin
          state_nx = ST_READ;
        end
      end
      ST_READ:   state_nx = ST_EXEC;
      ST_EXEC: begin
        if (alu_done) begin
          if (do_write) begin
            state_nx = ST_WRITE;
          end else begin
            state_nx = ST_IDLE;
            retire   = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        state_nx = ST_IDLE;
        retire   = 1'b1;
      end
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ir          <= '0;
      exec_first  <= 1'b0;
      dado        <= '0;
      instr_count <= '0;
    end else begin
      state      <= state_nx;
      // EXEC is only ever entered from READ, so this marks its first cycle.
      exec_first <= (state == ST_READ);
      if (state == ST_IDLE && instr_valid) ir <= instr;
      if (state == ST_EXEC && alu_done) dado <= alu_result;
      if (retire) instr_count <= instr_count + 16'd1;
    end
  end

  assign instr_ready  = (state == ST_IDLE);
  assign RW           = (state == ST_WRITE);
  assign alu_start    = (state == ST_EXEC) && exec_first;
  assign halted       = (state == ST_HALT);
  assign alu_op       = dec_alu_op;
  assign regA         = ADDR_W'(dec_ra);
  assign regB         = ADDR_W'(dec_rb);
  assign regC         = ADDR_W'(dec_rc);
  assign imediato     = DATA_W'(dec_imm);
  assign flagImediato = dec_imm_flag;

endmodule

// File: tb/tb_unidade_controle.sv
// tb/tb_unidade_controle.sv - self-checking bench for unidade_controle
module tb_unidade_controle;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic [DATA_W-1:0] alu_result;
  logic              alu_done;
  logic              alu_start;
  logic [3:0]        alu_op;
  logic [ADDR_W-1:0] regA, regB, regC;
  logic              RW;
  logic [DATA_W-1:0] imediato;
  logic              flagImediato;
  logic [DATA_W-1:0] dado;
  logic              halted;
  logic [15:0]       instr_count;

  int checks   = 0;
  int failures = 0;
  int model_count;
  int model_dado;

  always #5 clk = ~clk;

  unidade_controle #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_ready  (instr_ready),
    .alu_result   (alu_result),
    .alu_done     (alu_done),
    .alu_start    (alu_start),
    .alu_op       (alu_op),
    .regA         (regA),
    .regB         (regB),
    .regC         (regC),
    .RW           (RW),
    .imediato     (imediato),
    .flagImediato (flagImediato),
    .dado         (dado),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Expected decoded fields computed arithmetically from the instruction word.
  task automatic chk_fields(input int unsigned iw);
    int unsigned op;
    op = iw / (1 << 26);
    chk("alu_op",       alu_op,       op % 16);
    chk("flagImediato", flagImediato, op / 32);
    chk("regC",         regC,         (iw / (1 << 21)) % 32);
    chk("regA",         regA,         (iw / (1 << 16)) % 32);
    chk("regB",         regB,         (iw / (1 << 11)) % 32);
    chk("imediato",     imediato,     iw % 65536);
  endtask

  task automatic do_reset();
    rst = 1'b1; instr_valid = 1'b0; alu_done = 1'b0;
    step(); step();
    rst = 1'b0;
    model_count = 0; model_dado = 0;
    chk("rst_ready",  instr_ready,  1); chk("rst_rw",    RW,        0);
    chk("rst_start",  alu_start,    0); chk("rst_aluop", alu_op,    0);
    chk("rst_regA",   regA,         0); chk("rst_regB",  regB,      0);
    chk("rst_regC",   regC,         0); chk("rst_imm",   imediato,  0);
    chk("rst_flag",   flagImediato, 0); chk("rst_dado",  dado,      0);
    chk("rst_halted", halted,       0); chk("rst_count", instr_count, 0);
  endtask

  // Drives one instruction from IDLE; the ALU answers dly cycles after the first EXEC cycle.
  task automatic run_instr(input int unsigned iw, input int dly, input int unsigned res);
    int unsigned op, rc;
    bit wb;
    op = iw / (1 << 26);
    rc = (iw / (1 << 21)) % 32;
    wb = ((op / 16) % 2) == 1;
`ifdef UC_R0_ZERO_EN
    if (rc == 0) wb = 1'b0;
`endif
    chk("idle_ready", instr_ready, 1);
    chk("idle_rw",    RW,          0);
    chk("idle_count", instr_count, model_count);
    chk("idle_dado",  dado,        model_dado);
    instr_valid = 1'b1; instr = iw;
    step();
    // DECODE: garbage on inputs that must be ignored here
    instr_valid = 1'($urandom_range(0, 1)); instr = $urandom;
    alu_done = 1'($urandom_range(0, 1)); alu_result = 16'($urandom);
    chk_fields(iw);
    chk("dec_ready", instr_ready, 0);
    chk("dec_rw",    RW,          0);
    chk("dec_start", alu_start,   0);
    step();
    if (op == 63) begin
      model_count = (model_count + 1) % 65536;
      chk("halt_halted", halted,      1);
      chk("halt_ready",  instr_ready, 0);
      chk("halt_count",  instr_count, model_count);
      instr_valid = 1'b0; alu_done = 1'b0;
      return;
    end
    // READ
    alu_done = 1'($urandom_range(0, 1)); alu_result = 16'($urandom);
    chk_fields(iw);
    chk("read_rw",    RW,        0);
    chk("read_start", alu_start, 0);
    step();
    for (int k = 0; k <= dly; k++) begin
      chk("exec_start", alu_start,   (k == 0) ? 1 : 0);
      chk("exec_rw",    RW,          0);
      chk("exec_ready", instr_ready, 0);
      chk("exec_dado",  dado,        model_dado);
      alu_done   = (k == dly);
      alu_result = (k == dly) ? 16'(res) : 16'($urandom);
      step();
    end
    model_dado = res % 65536;
    if (wb) begin
      alu_done = 1'($urandom_range(0, 1)); alu_result = 16'($urandom);
      chk("wr_rw",    RW,          1);
      chk("wr_regC",  regC,        rc);
      chk("wr_dado",  dado,        model_dado);
      chk("wr_start", alu_start,   0);
      chk("wr_ready", instr_ready, 0);
      chk_fields(iw);
      step();
    end
    model_count = (model_count + 1) % 65536;
    instr_valid = 1'b0; alu_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0; alu_done = 1'b0; alu_result = '0;
    do_reset();

    run_instr({6'h11, 5'd3, 5'd1, 5'd2, 11'd0}, 0, 32'h1234);
    chk("count_after_first", instr_count, 1);
    run_instr({6'h31, 5'd4, 5'd7, 16'h00FF}, 3, 32'h0BCD);
    run_instr({6'h02, 5'd9, 5'd1, 16'hA5A5}, 0, 32'h5555);
    run_instr({6'h11, 5'd0, 5'd6, 16'h1800}, 1, 32'h7777);

    for (int n = 0; n < 40; n++) begin
      run_instr({6'($urandom_range(0, 62)), 26'($urandom)}, $urandom_range(0, 4), $urandom);
    end

    // Counter wrap: preload near the top, then retire across 16'hFFFF.
    dut.instr_count = 16'hFFFE;
    model_count = 65534;
    for (int n = 0; n < 4; n++) begin
      run_instr({6'($urandom_range(0, 62)), 26'($urandom)}, $urandom_range(0, 2), $urandom);
    end
    chk("wrap_count", instr_count, 2);

    // Reset during EXEC: no WRITE must follow.
    do_reset();
    instr_valid = 1'b1; instr = {6'h11, 5'd5, 5'd1, 5'd2, 11'd0};
    step();
    instr_valid = 1'b0;
    step(); step();
    chk("abort_in_exec", alu_start, 1);
    alu_done = 1'b1; alu_result = 16'hBEEF; rst = 1'b1;
    step();
    rst = 1'b0; alu_done = 1'b0;
    chk("abort_rw",    RW,          0);
    chk("abort_ready", instr_ready, 1);
    chk("abort_regC",  regC,        0);
    chk("abort_dado",  dado,        0);
    chk("abort_count", instr_count, 0);
    step();
    chk("abort_rw2",   RW,          0);
    chk("abort_ready2", instr_ready, 1);

    // HALT absorbs even with instr_valid held high.
    run_instr({6'h10, 5'd2, 5'd3, 16'h0042}, 0, 32'h0042);
    run_instr({6'h3F, 26'h0}, 0, 0);
    instr_valid = 1'b1; instr = {6'h11, 5'd1, 5'd1, 5'd1, 11'd0};
    for (int n = 0; n < 10; n++) begin
      step();
      chk("halt_hold_halted", halted,      1);
      chk("halt_hold_ready",  instr_ready, 0);
      chk("halt_hold_rw",     RW,          0);
      chk("halt_hold_count",  instr_count, model_count);
    end
    do_reset();
    step();
    chk("post_halt_ready", instr_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
